// File: rtl/inv_firstround.sv
// inv_firstround: first AES-128 decryption round.
// AddRoundKey(KEY_ROUND) -> InvShiftRows on accept, then InvSubBytes iterated
// BPC bytes per cycle, result held with a valid/ready handshake.
module inv_firstround #(
    parameter int BPC       = 4,
    parameter int KEY_ROUND = 10
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1407:0]   key,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [127:0]    state,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [127:0]    out
);

    localparam int NSTEP = 16 / BPC;
    localparam int CW    = (NSTEP > 1) ? $clog2(NSTEP) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(NSTEP - 1);

    // FIPS-197 inverse S-box, entry b at bits [2047-8*b -: 8]
    localparam logic [2047:0] INV_SBOX_TBL = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {
        IDLE,
        SUB,
        DONE
    } fsm_t;

    fsm_t            fsm;
    fsm_t            fsm_nxt;
    logic [CW-1:0]   cnt;
    logic [127:0]    work;
    logic [127:0]    work_sub;
    logic [127:0]    rk;

    assign rk = key[1407-128*KEY_ROUND -: 128];

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        int unsigned idx;
        idx = 32'(b);
        return INV_SBOX_TBL[2047-8*idx -: 8];
    endfunction

    // Row r rotates right by r: out(r,c) = in(r,(c-r) mod 4), byte index 4*c+r
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] res;
        res = '0;
        for (int unsigned c = 0; c < 4; c++) begin
            for (int unsigned r = 0; r < 4; r++) begin
                res[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+4-r)%4)+r) -: 8];
            end
        end
        return res;
    endfunction

    // Substitute the BPC bytes selected by cnt; all other bytes pass through
    always_comb begin
        work_sub = work;
        for (int unsigned j = 0; j < BPC; j++) begin
            int unsigned idx;
            idx = 32'(cnt) * BPC + j;
            work_sub[127-8*idx -: 8] = inv_sbox(work[127-8*idx -: 8]);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm <= IDLE;
        end else begin
            fsm <= fsm_nxt;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        fsm_nxt   = fsm;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (fsm)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) fsm_nxt = SUB;
            end
            SUB: begin
                if (cnt == CNT_LAST) fsm_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) fsm_nxt = IDLE;
            end
            default: fsm_nxt = IDLE;
        endcase
    end

    // Datapath: load on accept, substitute per step, publish on the last step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt  <= '0;
            work <= '0;
            out  <= '0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        work <= inv_shift_rows(state ^ rk);
                        cnt  <= '0;
                    end
                end
                SUB: begin
                    work <= work_sub;
                    cnt  <= cnt + CW'(1);
                    if (cnt == CNT_LAST) out <= work_sub;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inv_firstround.sv
// tb_inv_firstround: scoreboard bench for inv_firstround (BPC=4 main instance,
// plus BPC=1/2/16 instances for the latency sweep).
module tb_inv_firstround;

    localparam logic [127:0] C1_ST  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C1_RK  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
    localparam logic [127:0] C1_OUT = 128'hbd6e7c3df2b5779e0b61216e8b10b689;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [1407:0] key = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [127:0]  state = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [127:0]  out;

    logic          sw_valid = 1'b0;
    logic          sw_iready [3];
    logic          sw_ovalid [3];
    logic [127:0]  sw_out [3];

    int            n_vec = 0;
    int            n_err = 0;
    int            cyc = 0;
    logic [127:0]  sb [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    inv_firstround #(.BPC(4), .KEY_ROUND(10)) dut (
        .clk(clk), .rst(rst), .key(key), .in_valid(in_valid), .in_ready(in_ready),
        .state(state), .out_valid(out_valid), .out_ready(out_ready), .out(out)
    );

    inv_firstround #(.BPC(1), .KEY_ROUND(10)) u_bpc1 (
        .clk(clk), .rst(rst), .key(key), .in_valid(sw_valid), .in_ready(sw_iready[0]),
        .state(state), .out_valid(sw_ovalid[0]), .out_ready(1'b1), .out(sw_out[0])
    );

    inv_firstround #(.BPC(2), .KEY_ROUND(10)) u_bpc2 (
        .clk(clk), .rst(rst), .key(key), .in_valid(sw_valid), .in_ready(sw_iready[1]),
        .state(state), .out_valid(sw_ovalid[1]), .out_ready(1'b1), .out(sw_out[1])
    );

    inv_firstround #(.BPC(16), .KEY_ROUND(10)) u_bpc16 (
        .clk(clk), .rst(rst), .key(key), .in_valid(sw_valid), .in_ready(sw_iready[2]),
        .state(state), .out_valid(sw_ovalid[2]), .out_ready(1'b1), .out(sw_out[2])
    );

    // ---------------- reference model (GF(2^8) arithmetic, no lookup table)
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p  = '0;
        logic [7:0] aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r    = 8'h01;
        logic [7:0] base = a;
        logic [7:0] e    = 8'd254;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, base);
            base = gmul(base, base);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_sbox_m(input logic [7:0] y);
        logic [7:0] b;
        logic [7:0] d = 8'h05;
        for (int i = 0; i < 8; i++)
            b[i] = y[(i+2)%8] ^ y[(i+5)%8] ^ y[(i+7)%8] ^ d[i];
        return ginv(b);
    endfunction

    function automatic logic [127:0] model(input logic [127:0] st, input logic [127:0] rkey);
        logic [127:0] x   = st ^ rkey;
        logic [127:0] res = '0;
        logic [7:0]   m [4][4];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = x[127-8*(4*c+r) -: 8];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                res[127-8*(4*c+r) -: 8] = inv_sbox_m(m[r][(c+4-r)%4]);
        return res;
    endfunction

    function automatic logic [1407:0] mk_key(input logic [127:0] rkey);
        logic [1407:0] k;
        for (int i = 0; i < 44; i++) k[32*i +: 32] = $urandom;
        k[127:0] = rkey;
        return k;
    endfunction

    // ---------------- scoreboard: compare every output handshake
    always begin
        @(negedge clk);
        #1;
        if (rst && out_valid && out_ready) begin
            n_vec++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL sb_extra: out=%h, no result expected", out);
            end else begin
                logic [127:0] exp_v;
                exp_v = sb.pop_front();
                if (out !== exp_v) begin
                    n_err++;
                    $display("FAIL sb_out: got %h, expected %h", out, exp_v);
                end
            end
        end
    end

    // ---------------- stimulus helpers (called at a negedge)
    task automatic send(input logic [127:0] st, input logic [1407:0] k);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_err++;
            $display("FAIL send_timeout: in_ready=%b, expected 1", in_ready);
        end
        state = st;
        key = k;
        in_valid = 1'b1;
        sb.push_back(model(st, k[127:0]));
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Returns edges from accept (accept edge counted as 1) to out_valid
    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // ---------------- tests
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== 128'h0) begin
            n_err++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b out=%h, expected 1 0 0",
                     in_ready, out_valid, out);
        end
        rst = 1'b1;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, expected 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_fips();
        int lat;
        out_ready = 1'b1;
        send(C1_ST, mk_key(C1_RK));
        wait_out(lat);
        n_vec++;
        if (lat !== 5) begin
            n_err++;
            $display("FAIL fips_latency: got %0d edges, expected 5", lat);
        end
        n_vec++;
        if (out !== C1_OUT || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL fips_out: out=%h in_ready=%b, expected %h 0", out, in_ready, C1_OUT);
        end
        @(negedge clk);
    endtask

    task automatic test_zero();
        int lat;
        send(128'h0, mk_key(128'h0));
        wait_out(lat);
        n_vec++;
        if (out !== {16{8'h52}} || lat !== 5) begin
            n_err++;
            $display("FAIL zero_vec: out=%h lat=%0d, expected %h lat 5", out, lat, {16{8'h52}});
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        int lat;
        int bad = 0;
        out_ready = 1'b0;
        send(C1_ST, mk_key(C1_RK));
        wait_out(lat);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            n_vec++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out !== C1_OUT) begin
                n_err++;
                bad++;
                if (bad < 4)
                    $display("FAIL bp_hold: cycle %0d out_valid=%b in_ready=%b out=%h, expected 1 0 %h",
                             i, out_valid, in_ready, out, C1_OUT);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        n_vec++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out !== C1_OUT) begin
            n_err++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b out=%h, expected 1 0 %h",
                     in_ready, out_valid, out, C1_OUT);
        end
    endtask

    task automatic test_ignored();
        int lat;
        int extra = 0;
        out_ready = 1'b1;
        send(C1_ST, mk_key(C1_RK));
        for (int i = 0; i < 3; i++) begin
            state = {$urandom, $urandom, $urandom, $urandom};
            key = mk_key({$urandom, $urandom, $urandom, $urandom});
            in_valid = 1'($urandom_range(1, 0));
            @(negedge clk);
        end
        in_valid = 1'b0;
        wait_out(lat);
        n_vec++;
        if (out !== C1_OUT || out_valid !== 1'b1) begin
            n_err++;
            $display("FAIL ignored_out: out=%h out_valid=%b, expected %h 1", out, out_valid, C1_OUT);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) extra++;
        end
        n_vec++;
        if (extra !== 0) begin
            n_err++;
            $display("FAIL ignored_extra: %0d extra out_valid cycles, expected 0", extra);
        end
    endtask

    task automatic test_reset_midop();
        int lat;
        send(C1_ST, mk_key(C1_RK));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        sb.delete();
        #1;
        n_vec++;
        if (out_valid !== 1'b0 || out !== 128'h0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midop_reset: out_valid=%b out=%h in_ready=%b, expected 0 0 1",
                     out_valid, out, in_ready);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        n_vec++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_err++;
            $display("FAIL midop_idle: out_valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
        end
        send(C1_ST, mk_key(C1_RK));
        wait_out(lat);
        n_vec++;
        if (out !== C1_OUT || lat !== 5) begin
            n_err++;
            $display("FAIL midop_restart: out=%h lat=%0d, expected %h lat 5", out, lat, C1_OUT);
        end
        @(negedge clk);
    endtask

    // 16 blocks whose post-key bytes cover all 256 values; in_valid held high
    task automatic test_back_to_back();
        int prev = 0;
        int t;
        out_ready = 1'b1;
        for (int b = 0; b < 16; b++) begin
            logic [127:0] rkey;
            logic [127:0] pat;
            t = 0;
            while (!in_ready && t < 40) begin
                @(negedge clk);
                t++;
            end
            if (t >= 40) begin
                n_err++;
                $display("FAIL b2b_timeout: block %0d never accepted", b);
            end
            rkey = {$urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < 16; i++) pat[127-8*i -: 8] = 8'(16*b + i);
            state = pat ^ rkey;
            key = mk_key(rkey);
            in_valid = 1'b1;
            sb.push_back(model(pat ^ rkey, rkey));
            if (b > 0) begin
                n_vec++;
                if (cyc - prev !== 6) begin
                    n_err++;
                    $display("FAIL b2b_spacing: block %0d accepted %0d cycles after previous, expected 6",
                             b, cyc - prev);
                end
            end
            prev = cyc;
            @(negedge clk);
        end
        in_valid = 1'b0;
        t = 0;
        while (sb.size() > 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        @(negedge clk);
        n_vec++;
        if (sb.size() !== 0) begin
            n_err++;
            $display("FAIL b2b_drain: %0d results outstanding, expected 0", sb.size());
        end
    endtask

    task automatic test_sweep();
        int lat [3];
        logic [127:0] val [3];
        int exp_lat [3];
        exp_lat[0] = 17;
        exp_lat[1] = 9;
        exp_lat[2] = 2;
        for (int i = 0; i < 3; i++) begin
            lat[i] = 0;
            val[i] = '0;
        end
        state = C1_ST;
        key = mk_key(C1_RK);
        sw_valid = 1'b1;
        for (int e = 1; e <= 25; e++) begin
            @(negedge clk);
            if (e == 1) sw_valid = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (sw_ovalid[i] && lat[i] == 0) begin
                    lat[i] = e;
                    val[i] = sw_out[i];
                end
            end
        end
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (lat[i] !== exp_lat[i] || val[i] !== C1_OUT) begin
                n_err++;
                $display("FAIL sweep_%0d: lat=%0d out=%h, expected lat %0d out %h",
                         i, lat[i], val[i], exp_lat[i], C1_OUT);
            end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_fips();
        test_zero();
        test_backpressure();
        test_ignored();
        test_reset_midop();
        test_back_to_back();
        test_sweep();
        repeat (3) @(negedge clk);
        n_vec++;
        if (sb.size() !== 0) begin
            n_err++;
            $display("FAIL sb_leftover: %0d results never produced", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
